// File: rtl/fibo_request_controller.sv
// Batch driver for one fibonacci calculator: runs the calculator once per index and
// streams {index, value, error, last}. Optional history check: FIBO_CTRL_CHECK_EN.
module fibo_request_controller #(
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 16,
    parameter int MAX_IDX = 24,
    parameter int TIMEOUT = 40
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_first,
    input  logic [IDX_W-1:0]  req_count,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W:0]    res_index,
    output logic [DATA_W-1:0] res_value,
    output logic              res_error,
    output logic              res_last,
    output logic              calc_reset,
    output logic              calc_begin,
    output logic [IDX_W-1:0]  calc_input_s,
    input  logic              calc_done,
    input  logic [DATA_W-1:0] calc_value,
    output logic [2:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; the source holds its payload stable while valid is high and ready is low.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHK   = 3'd1,
        S_CLR   = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_OUT   = 3'd5
    } state_e;

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0]   MAX_IDX_C = (IDX_W + 1)'(MAX_IDX);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    state_e              state_q;
    logic [IDX_W:0]      idx_q;
    logic [IDX_W-1:0]    rem_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                req_ready_q;
    logic                calc_reset_q;
    logic                calc_begin_q;
    logic [IDX_W-1:0]    calc_input_q;
    logic                res_valid_q;
    logic [IDX_W:0]      res_index_q;
    logic [DATA_W-1:0]   res_value_q;
    logic                res_error_q;
    logic                res_last_q;

    logic bad_idx;
    logic tmo_hit;
    logic check_fail;

    assign bad_idx = (idx_q == '0) || (idx_q > MAX_IDX_C);
    assign tmo_hit = (tmo_q == TMO_LAST);

`ifdef FIBO_CTRL_CHECK_EN
    // Two most recent good values of this batch; they are always consecutive indices
    // because any error result wipes the history.
    logic [DATA_W-1:0] hist_old_q;
    logic [DATA_W-1:0] hist_new_q;
    logic [1:0]        hist_n_q;
    logic [DATA_W-1:0] hist_sum;
    logic              hist_push;
    logic              hist_clear;

    assign hist_sum   = hist_old_q + hist_new_q;
    assign check_fail = (hist_n_q == 2'd2) && (calc_value != hist_sum);
    assign hist_push  = (state_q == S_WAIT) && calc_done && !check_fail;
    assign hist_clear = (state_q == S_IDLE)
                     || ((state_q == S_CHK) && bad_idx)
                     || ((state_q == S_WAIT) && calc_done && check_fail)
                     || ((state_q == S_WAIT) && !calc_done && tmo_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_old_q <= '0;
            hist_new_q <= '0;
            hist_n_q   <= 2'd0;
        end else if (hist_clear) begin
            hist_n_q <= 2'd0;
        end else if (hist_push) begin
            hist_old_q <= hist_new_q;
            hist_new_q <= calc_value;
            hist_n_q   <= (hist_n_q == 2'd2) ? 2'd2 : hist_n_q + 2'd1;
        end
    end
`else
    assign check_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            rem_q        <= '0;
            tmo_q        <= '0;
            req_ready_q  <= 1'b1;
            calc_reset_q <= 1'b1;
            calc_begin_q <= 1'b0;
            calc_input_q <= '0;
            res_valid_q  <= 1'b0;
            res_index_q  <= '0;
            res_value_q  <= '0;
            res_error_q  <= 1'b0;
            res_last_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    calc_reset_q <= 1'b0;
                    if (req_valid && req_ready_q && (req_count != '0)) begin
                        idx_q       <= {1'b0, req_first};
                        rem_q       <= req_count;
                        req_ready_q <= 1'b0;
                        state_q     <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (bad_idx) begin
                        res_valid_q <= 1'b1;
                        res_index_q <= idx_q;
                        res_value_q <= '0;
                        res_error_q <= 1'b1;
                        res_last_q  <= (rem_q == IDX_W'(1));
                        state_q     <= S_OUT;
                    end else begin
                        calc_reset_q <= 1'b1;
                        state_q      <= S_CLR;
                    end
                end
                S_CLR: begin
                    calc_reset_q <= 1'b0;
                    calc_begin_q <= 1'b1;
                    calc_input_q <= idx_q[IDX_W-1:0];
                    state_q      <= S_START;
                end
                S_START: begin
                    calc_begin_q <= 1'b0;
                    tmo_q        <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (calc_done || tmo_hit) begin
                        res_valid_q <= 1'b1;
                        res_index_q <= idx_q;
                        res_value_q <= calc_done ? calc_value : '0;
                        res_error_q <= calc_done ? check_fail : 1'b1;
                        res_last_q  <= (rem_q == IDX_W'(1));
                        state_q     <= S_OUT;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        rem_q       <= rem_q - 1'b1;
                        if (res_last_q) begin
                            req_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_CHK;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign res_valid    = res_valid_q;
    assign res_index    = res_index_q;
    assign res_value    = res_value_q;
    assign res_error    = res_error_q;
    assign res_last     = res_last_q;
    assign calc_reset   = calc_reset_q;
    assign calc_begin   = calc_begin_q;
    assign calc_input_s = calc_input_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fibo_request_controller.sv
// Bench for fibo_request_controller: behavioural calculator, batch-level reference
// model feeding an expected queue, and one task per scenario.
module tb_fibo_request_controller;

    localparam int IDX_W   = 5;
    localparam int DATA_W  = 16;
    localparam int MAX_IDX = 24;
    localparam int TIMEOUT = 40;
    localparam int RW      = IDX_W + 1 + DATA_W + 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [IDX_W-1:0]  req_first = '0;
    logic [IDX_W-1:0]  req_count = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [IDX_W:0]    res_index;
    logic [DATA_W-1:0] res_value;
    logic              res_error;
    logic              res_last;
    logic              calc_reset;
    logic              calc_begin;
    logic [IDX_W-1:0]  calc_input_s;
    logic              calc_done = 1'b0;
    logic [DATA_W-1:0] calc_value = '0;
    logic [2:0]        dbg_state;

    fibo_request_controller #(
        .IDX_W(IDX_W), .DATA_W(DATA_W), .MAX_IDX(MAX_IDX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_first(req_first), .req_count(req_count),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_index(res_index), .res_value(res_value),
        .res_error(res_error), .res_last(res_last),
        .calc_reset(calc_reset), .calc_begin(calc_begin),
        .calc_input_s(calc_input_s), .calc_done(calc_done),
        .calc_value(calc_value), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];

    // behavioural calculator: random latency, optional hang and one injected wrong value
    logic              hang   = 1'b0;
    logic              inj_en = 1'b0;
    int                inj_idx = 0;
    logic [DATA_W-1:0] inj_val = '0;
    logic              busy = 1'b0;
    int                lat = 0;
    logic [DATA_W-1:0] tgt = '0;
    int                begin_cycles = 0;

    function automatic logic [DATA_W-1:0] fib(input int n);
        int a = 0;
        int b = 1;
        int t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] calc_answer(input int n);
        if (inj_en && n == inj_idx) return inj_val;
        return fib(n);
    endfunction

    always @(posedge clk) begin
        if (calc_reset) begin
            calc_done <= 1'b0;
            busy      <= 1'b0;
        end else if (calc_begin) begin
            busy       <= 1'b1;
            lat        <= $urandom_range(1, 6);
            tgt        <= calc_answer(int'(calc_input_s));
            calc_done  <= 1'b0;
            calc_value <= DATA_W'($urandom);
        end else if (busy && !hang) begin
            if (lat <= 1) begin
                calc_done  <= 1'b1;
                calc_value <= tgt;
                busy       <= 1'b0;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    always @(negedge clk) if (calc_begin) begin_cycles++;

    // reference model: expected results of one batch from the batch rules
    task automatic model_batch(input int first, input int count);
        logic [DATA_W-1:0] h[$];
        for (int i = 0; i < count; i++) begin
            int idx;
            logic err;
            logic [DATA_W-1:0] v;
            logic [DATA_W-1:0] s;
            logic last;
            idx  = first + i;
            last = (i == count - 1);
            if (idx == 0 || idx > MAX_IDX || hang) begin
                err = 1'b1;
                v   = '0;
                h.delete();
            end else begin
                v   = calc_answer(idx);
                err = 1'b0;
`ifdef FIBO_CTRL_CHECK_EN
                if (h.size() == 2) begin
                    s = h[0] + h[1];
                    if (v != s) err = 1'b1;
                end
                if (err) h.delete();
                else begin
                    h.push_back(v);
                    if (h.size() > 2) void'(h.pop_front());
                end
`endif
            end
            exp_q.push_back({idx[IDX_W:0], v, err, last});
        end
    endtask

    // driver tasks
    task automatic drive_req(input int first, input int count);
        int cyc = 0;
        @(negedge clk);
        while (!req_ready && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
        end
        req_first = first[IDX_W-1:0];
        req_count = count[IDX_W-1:0];
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_first = IDX_W'($urandom);
        req_count = IDX_W'($urandom);
    endtask

    task automatic collect(input int n, input int ready_pct);
        int got = 0;
        int cyc = 0;
        int budget;
        budget = n * 250 + 50;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            res_ready = ($urandom_range(0, 99) < ready_pct);
            if (res_valid && res_ready) begin
                got_q.push_back({res_index, res_value, res_error, res_last});
                got++;
            end
        end
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || calc_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_high: req_ready=%b calc_reset=%b required 1 1", req_ready, calc_reset);
        end
        checks++;
        if ({res_valid, res_index, res_value, res_error, res_last, calc_begin, calc_input_s} !== '0) begin
            errors++;
            $display("FAIL reset_low: res_valid=%b idx=%0d val=%0d err=%b last=%b begin=%b in=%0d required all 0",
                     res_valid, res_index, res_value, res_error, res_last, calc_begin, calc_input_s);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (calc_reset !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: calc_reset=%b req_ready=%b required 0 1", calc_reset, req_ready);
        end
    endtask

    task automatic test_basic();
        logic [RW-1:0] e, g;
        model_batch(1, 5);
        drive_req(1, 5);
        collect(5, 70);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d results required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL basic_result: got %h required %h", g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_single();
        logic [RW-1:0] e, g;
        begin_cycles = 0;
        model_batch(10, 1);
        drive_req(10, 1);
        collect(1, 100);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d results required 1", got_q.size());
        end
        if (got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL single_result: got %h required %h", g, e);
            end
        end
        checks++;
        if (begin_cycles != 1) begin
            errors++;
            $display("FAIL single_begin_pulse: calc_begin high %0d cycles required 1", begin_cycles);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_bad_index();
        logic [RW-1:0] e, g;
        begin_cycles = 0;
        model_batch(0, 2);
        drive_req(0, 2);
        collect(2, 60);
        checks++;
        if (begin_cycles != 1) begin
            errors++;
            $display("FAIL bad_index_runs: calculator started %0d times required 1", begin_cycles);
        end
        model_batch(23, 3);
        drive_req(23, 3);
        collect(3, 60);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bad_index_count: got %0d results required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL bad_index_result: got %h required %h", g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_wide();
        logic [RW-1:0] e, g;
        begin_cycles = 0;
        model_batch(31, 31);
        drive_req(31, 31);
        collect(31, 100);
        checks++;
        if (got_q.size() != exp_q.size() || begin_cycles != 0) begin
            errors++;
            $display("FAIL wide_count: got %0d results %0d runs required %0d results 0 runs",
                     got_q.size(), begin_cycles, exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL wide_result: got %h required %h", g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_zero_count();
        logic bad = 1'b0;
        drive_req(5, 0);
        res_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || req_ready !== 1'b1 || calc_begin !== 1'b0) bad = 1'b1;
        end
        res_ready = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL zero_count: activity seen after count=0 request, required none");
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        drive_req(7, 1);
        res_ready = 1'b0;
        while (!res_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_value !== 16'd13 || res_index !== 6'd7 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: valid=%b val=%0d idx=%0d req_ready=%b required 1 13 7 0",
                         res_valid, res_value, res_index, req_ready);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: valid=%b req_ready=%b required 0 1", res_valid, req_ready);
        end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        logic bad = 1'b0;
        hang = 1'b1;
        drive_req(3, 1);
        while (!res_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        // CHK, CLR and START take one cycle each ahead of the WAIT budget
        checks++;
        if (cyc != TIMEOUT + 3) begin
            errors++;
            $display("FAIL timeout_latency: result after %0d cycles required %0d", cyc, TIMEOUT + 3);
        end
        checks++;
        if ({res_valid, res_index, res_value, res_error, res_last} !== {1'b1, 6'd3, 16'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL timeout_result: valid=%b idx=%0d val=%0d err=%b last=%b required 1 3 0 1 1",
                     res_valid, res_index, res_value, res_error, res_last);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        drive_req(5, 3);
        repeat (15) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || calc_reset !== 1'b1 || res_valid !== 1'b0 || calc_begin !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset: req_ready=%b calc_reset=%b valid=%b begin=%b required 1 1 0 0",
                     req_ready, calc_reset, res_valid, calc_begin);
        end
        @(negedge clk);
        reset_n = 1'b1;
        hang = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        res_ready = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midwait_spurious: result or busy seen after reset, required idle");
        end
    endtask

    task automatic test_check_inject();
        logic [RW-1:0] e, g;
        inj_en  = 1'b1;
        inj_idx = 6;
        inj_val = 16'd9;
        model_batch(4, 4);
        drive_req(4, 4);
        collect(4, 80);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL inject_count: got %0d results required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL inject_result: got %h required %h", g, e);
            end
        end
        inj_en = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] e, g;
        for (int t = 0; t < 12; t++) begin
            int first, count, pct;
            first = $urandom_range(0, 31);
            count = $urandom_range(0, 6);
            pct   = $urandom_range(30, 100);
            model_batch(first, count);
            drive_req(first, count);
            collect(count, pct);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL b2b_count: batch %0d/%0d got %0d results required %0d",
                         first, count, got_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front();
                g = got_q.pop_front();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL b2b_result: batch %0d/%0d got %h required %h", first, count, g, e);
                end
            end
            exp_q.delete();
            got_q.delete();
        end
    endtask

    // final report
    initial begin
        test_reset();
        test_basic();
        test_single();
        test_bad_index();
        test_wide();
        test_zero_count();
        test_backpressure();
        test_timeout();
        test_check_inject();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
